// File: rtl/adxl362_burst_cntrl.sv
// ADXL362 SPI burst controller.
// Runs one SPI mode-0 transaction per accepted start: command byte, register
// address byte, then N data bytes. Write data is pulled one byte at a time
// through wr_data_req; read data is delivered one byte at a time on rd_valid.
// SCLK is generated by dividing clk: each SCLK half-period lasts H clk cycles.

module adxl362_burst_cntrl #(
    parameter int  CLK_FREQUENCY  = 100_000_000,
    parameter int  SCLK_FREQUENCY = 500_000,
    parameter int  MAX_BURST      = 8,
    localparam int BCW            = $clog2(MAX_BURST + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           write,
    input  logic [7:0]     address,
    input  logic [BCW-1:0] byte_count,
    input  logic [7:0]     wr_data,
    output logic           wr_data_req,
    output logic [7:0]     rd_data,
    output logic           rd_valid,
    output logic           busy,
    output logic           done,
    output logic           SPI_SCLK,
    output logic           SPI_MOSI,
    output logic           SPI_CS,
    input  logic           SPI_MISO
);

    // clk cycles per SCLK half-period
    localparam int H  = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
    localparam int CW = (H > 2) ? $clog2(H) : 1;
    // byte index runs 0 (command), 1 (address), 2..N+1 (data)
    localparam int IW = $clog2(MAX_BURST + 2);

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CS_SETUP  = 3'd1;
    localparam logic [2:0] ST_SCLK_LOW  = 3'd2;
    localparam logic [2:0] ST_SCLK_HIGH = 3'd3;
    localparam logic [2:0] ST_CS_HOLD   = 3'd4;

    // A half-period shorter than two clk cycles leaves no room to sample MISO
    // and change MOSI in distinct cycles.
    generate
        if (H < 2) begin : g_bad_divider
            $error("adxl362_burst_cntrl: CLK_FREQUENCY/(2*SCLK_FREQUENCY) must be at least 2");
        end
    endgenerate

    // Index of the final byte of the frame for a requested burst length:
    // zero means one byte, anything above MAX_BURST is clamped.
    function automatic logic [IW-1:0] last_index(input logic [BCW-1:0] count);
        int n;
        n = int'(count);
        if (n == 0) begin
            n = 1;
        end else if (n > MAX_BURST) begin
            n = MAX_BURST;
        end
        return IW'(n + 1);
    endfunction

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] phase_cnt;
    logic [2:0]    bit_idx;
    logic [IW-1:0] byte_idx;
    logic [IW-1:0] last_byte;
    logic          is_write;
    logic [7:0]    addr_q;
    logic [7:0]    tx_shift;
    logic [7:0]    rx_shift;

    logic          phase_end;
    logic          start_accept;
    logic          high_end;
    logic          hold_end;
    logic          byte_end;
    logic          last_bit;
    logic [7:0]    cmd_byte;
    logic [7:0]    next_byte;
    logic [7:0]    rx_next;

    assign phase_end    = (phase_cnt == CW'(H - 1));
    // done is still high in the first IDLE cycle, which blocks an immediate restart
    assign start_accept = (state == ST_IDLE) && start && !done;
    assign high_end     = (state == ST_SCLK_HIGH) && phase_end;
    assign hold_end     = (state == ST_CS_HOLD) && phase_end;
    assign byte_end     = (bit_idx == 3'd7);
    assign last_bit     = byte_end && (byte_idx == last_byte);
    assign cmd_byte     = write ? CMD_WRITE : CMD_READ;
    // Byte loaded after the current one finishes: address after the command,
    // then the requested write byte (sampled this very cycle) or zeros on reads.
    assign next_byte    = (byte_idx == '0) ? addr_q : (is_write ? wr_data : 8'h00);
    assign rx_next      = {rx_shift[6:0], SPI_MISO};

    // Phase sequencing: every non-idle state lasts exactly one half-period.
    always_comb begin
        // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE:      if (start_accept) state_next = ST_CS_SETUP;
            ST_CS_SETUP:  if (phase_end)    state_next = ST_SCLK_LOW;
            ST_SCLK_LOW:  if (phase_end)    state_next = ST_SCLK_HIGH;
            ST_SCLK_HIGH: if (phase_end)    state_next = last_bit ? ST_CS_HOLD : ST_SCLK_LOW;
            ST_CS_HOLD:   if (phase_end)    state_next = ST_IDLE;
            default:                        state_next = ST_IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update on the same edge.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Half-period timer; restarts whenever a phase ends and stays cleared in IDLE.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE) || phase_end) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    // Transaction parameters and bit/byte position within the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_write  <= 1'b0;
            addr_q    <= 8'h00;
            last_byte <= '0;
            bit_idx   <= 3'd0;
            byte_idx  <= '0;
        end else if (start_accept) begin
            is_write  <= write;
            addr_q    <= address;
            last_byte <= last_index(byte_count);
            bit_idx   <= 3'd0;
            byte_idx  <= '0;
        end else if (high_end && !last_bit) begin
            if (byte_end) begin
                bit_idx  <= 3'd0;
                byte_idx <= byte_idx + 1'b1;
            end else begin
                bit_idx  <= bit_idx + 1'b1;
            end
        end
    end

    // Transmit shifter; its MSB is MOSI, so MOSI moves only when CS falls or
    // when a high phase ends (the SCLK falling edge), and returns to 0 in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= 8'h00;
        end else if (start_accept) begin
            tx_shift <= cmd_byte;
        end else if (high_end && !last_bit) begin
            tx_shift <= byte_end ? next_byte : {tx_shift[6:0], 1'b0};
        end else if (hold_end) begin
            tx_shift <= 8'h00;
        end
    end

    // Receive shifter: MISO is taken in the last cycle of each high phase;
    // command and address bytes are shifted through but never reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift <= 8'h00;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (high_end) begin
                rx_shift <= rx_next;
                if (byte_end && !is_write && (byte_idx >= IW'(2))) begin
                    rd_data  <= rx_next;
                    rd_valid <= 1'b1;
                end
            end
        end
    end

    // End-of-transaction pulse, coincident with the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= hold_end;
        end
    end

    // Write data is requested as the address byte and every data byte but the
    // last one finish, so the next byte is ready for the following falling edge.
    assign wr_data_req = is_write && high_end && byte_end && !last_bit && (byte_idx != '0);

    assign busy     = (state != ST_IDLE);
    assign SPI_CS   = (state == ST_IDLE);
    assign SPI_SCLK = (state == ST_SCLK_HIGH);
    assign SPI_MOSI = tx_shift[7];

endmodule

// File: tb/tb_adxl362_burst_cntrl.sv
// Self-checking bench for adxl362_burst_cntrl at default parameters.
// Contains an ADXL362-like SPI slave (register file with auto-increment),
// a protocol monitor for SCLK/CS/MOSI timing, a directed vector table,
// hand-written reset-abort and held-start sequences, and randomized
// transactions predicted by a transaction-level reference model.

module tb_adxl362_burst_cntrl;

    localparam int H         = 100_000_000 / (2 * 500_000);
    localparam int MAX_BURST = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       write;
    logic [7:0] address;
    logic [3:0] byte_count;
    logic [7:0] wr_data;
    logic       wr_data_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       SPI_SCLK;
    logic       SPI_MOSI;
    logic       SPI_CS;
    logic       SPI_MISO = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adxl362_burst_cntrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .write       (write),
        .address     (address),
        .byte_count  (byte_count),
        .wr_data     (wr_data),
        .wr_data_req (wr_data_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
        .SPI_SCLK    (SPI_SCLK),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_CS      (SPI_CS),
        .SPI_MISO    (SPI_MISO)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- ADXL362-like SPI slave ----------------
    logic [7:0] dev_regs [0:255];
    logic [7:0] ref_regs [0:255];
    logic [7:0] mosi_q [$];
    int         sbit = 0;
    logic [7:0] s_shift = 8'h00;
    logic [7:0] s_cmd = 8'h00;
    logic [7:0] s_ptr = 8'h00;

    always @(negedge SPI_CS) begin
        sbit = 0;
        s_cmd = 8'h00;
        mosi_q.delete();
        SPI_MISO = 1'($urandom_range(0, 1));
    end

    always @(posedge SPI_SCLK) begin
        if (SPI_CS === 1'b0) begin
            s_shift = {s_shift[6:0], SPI_MOSI};
            sbit++;
            if (sbit % 8 == 0) begin
                mosi_q.push_back(s_shift);
                if (sbit == 8) begin
                    s_cmd = s_shift;
                end else if (sbit == 16) begin
                    s_ptr = s_shift;
                end else begin
                    if (s_cmd == 8'h0A) dev_regs[s_ptr] = s_shift;
                    s_ptr = s_ptr + 8'd1;
                end
            end
        end
    end

    // Mode 0: the slave shifts out on the falling edge; before the data phase it drives noise.
    always @(negedge SPI_SCLK) begin
        if (SPI_CS === 1'b0) begin
            if (s_cmd == 8'h0B && sbit >= 16) SPI_MISO = dev_regs[s_ptr][7 - (sbit % 8)];
            else                              SPI_MISO = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- SPI protocol monitor ----------------
    logic mon_en = 1'b0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;
    logic prev_mosi = 1'b0;
    logic first_rise = 1'b0;
    logic mosi_moved = 1'b0;
    int   run = 0;
    int   idle_bad = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (SPI_CS === 1'b1) begin
                if (SPI_SCLK !== 1'b0 || SPI_MOSI !== 1'b0) idle_bad++;
                if (prev_cs === 1'b0) begin
                    check("cs_hold_cycles", 64'(run), 64'(H));
                    check("mosi_quiet_hold", 64'(mosi_moved), 64'd0);
                end
            end else if (prev_cs === 1'b1) begin
                run = 1;
                first_rise = 1'b1;
                mosi_moved = 1'b0;
            end else if (SPI_SCLK === 1'b1 && prev_sclk === 1'b0) begin
                if (SPI_MOSI !== prev_mosi) mosi_moved = 1'b1;
                check("sclk_low_cycles", 64'(run), first_rise ? 64'(2 * H) : 64'(H));
                check("mosi_quiet_low", 64'(mosi_moved), 64'd0);
                run = 1;
                first_rise = 1'b0;
                mosi_moved = 1'b0;
            end else if (SPI_SCLK === 1'b0 && prev_sclk === 1'b1) begin
                check("sclk_high_cycles", 64'(run), 64'(H));
                check("mosi_quiet_high", 64'(mosi_moved), 64'd0);
                run = 1;
                mosi_moved = 1'b0;
            end else begin
                run++;
                if (SPI_MOSI !== prev_mosi) mosi_moved = 1'b1;
            end
        end
        prev_cs   = SPI_CS;
        prev_sclk = SPI_SCLK;
        prev_mosi = SPI_MOSI;
    end

    // ---------------- transaction helpers ----------------
    // Called at a falling clk edge with the controller idle and done low.
    task automatic launch(input logic wr, input logic [7:0] addr, input logic [3:0] bc, input logic keep);
        write      = wr;
        address    = addr;
        byte_count = bc;
        wr_data    = 8'h00;
        start      = 1'b1;
        @(negedge clk);
        if (!keep) start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("cs_after_start", 64'(SPI_CS), 64'd0);
    endtask

    // Follows a transaction from its first busy cycle to the cycle after done.
    task automatic collect(input string tag, input logic wr, input logic [7:0] addr,
                           input logic [63:0] wbytes, input int exp_n, input int exp_busy,
                           input logic [63:0] exp_rd);
        int          cycles = 1;
        int          nrd = 0;
        int          nreq = 0;
        logic [63:0] got_rd = '0;
        logic [7:0]  a;
        for (int i = 0; i < 40000 && busy === 1'b1; i++) begin
            @(negedge clk);
            if (busy === 1'b1) cycles++;
            if (wr_data_req === 1'b1) begin
                if (nreq < 8) wr_data = wbytes[8 * nreq +: 8];
                nreq++;
            end
            if (rd_valid === 1'b1) begin
                if (nrd < 8) got_rd[8 * nrd +: 8] = rd_data;
                nrd++;
            end
        end
        check({tag, ":busy_cycles"}, 64'(cycles), 64'(exp_busy));
        check({tag, ":done_pulse"}, 64'(done), 64'd1);
        check({tag, ":cs_released"}, 64'(SPI_CS), 64'd1);
        check({tag, ":sclk_idle"}, 64'(SPI_SCLK), 64'd0);
        check({tag, ":rd_valid_count"}, 64'(nrd), wr ? 64'd0 : 64'(exp_n));
        check({tag, ":wr_req_count"}, 64'(nreq), wr ? 64'(exp_n) : 64'd0);
        if (!wr) check({tag, ":rd_bytes"}, got_rd, exp_rd);
        check({tag, ":mosi_byte_count"}, 64'(mosi_q.size()), 64'(2 + exp_n));
        check({tag, ":mosi_cmd"}, (mosi_q.size() > 0) ? 64'(mosi_q[0]) : 64'h100, wr ? 64'h0A : 64'h0B);
        check({tag, ":mosi_addr"}, (mosi_q.size() > 1) ? 64'(mosi_q[1]) : 64'h100, 64'(addr));
        if (wr) begin
            for (int k = 0; k < exp_n; k++) begin
                a = addr + 8'(k);
                check($sformatf("%s:mosi_data%0d", tag, k),
                      (mosi_q.size() > 2 + k) ? 64'(mosi_q[2 + k]) : 64'h100, 64'(wbytes[8 * k +: 8]));
                check($sformatf("%s:dev_reg%0d", tag, k), 64'(dev_regs[a]), 64'(wbytes[8 * k +: 8]));
            end
        end
        @(negedge clk);
        check({tag, ":done_one_cycle"}, 64'(done), 64'd0);
    endtask

    // Reference model: burst length and duration from the frame rules, data from a shadow register file.
    function automatic int burst_n(input int bc);
        if (bc == 0) return 1;
        if (bc > MAX_BURST) return MAX_BURST;
        return bc;
    endfunction

    task automatic ref_write(input logic [7:0] addr, input int n, input logic [63:0] wbytes);
        logic [7:0] a;
        for (int k = 0; k < n; k++) begin
            a = addr + 8'(k);
            ref_regs[a] = wbytes[8 * k +: 8];
        end
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [3:0]  bc;
        logic [63:0] wbytes;
        int          exp_n;
        int          exp_busy;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int          done_seen;
        logic        r_wr;
        logic [7:0]  r_addr;
        logic [3:0]  r_bc;
        logic [63:0] r_wb;
        logic [63:0] r_rd;
        logic [7:0]  a;
        int          r_n;

        for (int i = 0; i < 256; i++) dev_regs[i] = 8'h00;
        dev_regs[0] = 8'hAD;
        dev_regs[1] = 8'h1D;
        dev_regs[2] = 8'hF2;
        for (int i = 0; i < 256; i++) ref_regs[i] = dev_regs[i];

        vecs[0] = '{1'b0, 8'h00, 4'd1,  64'h0,                 1, 5000,  64'h0000_0000_0000_00AD};
        vecs[1] = '{1'b0, 8'h00, 4'd3,  64'h0,                 3, 8200,  64'h0000_0000_00F2_1DAD};
        vecs[2] = '{1'b1, 8'h1F, 4'd1,  64'h52,                1, 5000,  64'h0};
        vecs[3] = '{1'b0, 8'h1F, 4'd0,  64'h0,                 1, 5000,  64'h0000_0000_0000_0052};
        vecs[4] = '{1'b1, 8'h20, 4'd15, 64'h8877_6655_4433_2211, 8, 16200, 64'h0};

        rst = 1'b1;
        start = 1'b0;
        write = 1'b0;
        address = 8'h00;
        byte_count = 4'd0;
        wr_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset:cs", 64'(SPI_CS), 64'd1);
        check("reset:sclk", 64'(SPI_SCLK), 64'd0);
        check("reset:mosi", 64'(SPI_MOSI), 64'd0);
        check("reset:busy", 64'(busy), 64'd0);
        check("reset:done", 64'(done), 64'd0);
        check("reset:rd_valid", 64'(rd_valid), 64'd0);
        check("reset:wr_data_req", 64'(wr_data_req), 64'd0);
        check("reset:rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            launch(vecs[i].wr, vecs[i].addr, vecs[i].bc, 1'b0);
            collect($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wbytes,
                    vecs[i].exp_n, vecs[i].exp_busy, vecs[i].exp_rd);
            if (vecs[i].wr) ref_write(vecs[i].addr, vecs[i].exp_n, vecs[i].wbytes);
        end

        // Reset about 1000 cycles into a read
        launch(1'b0, 8'h00, 4'd1, 1'b0);
        repeat (998) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort:cs", 64'(SPI_CS), 64'd1);
        check("abort:sclk", 64'(SPI_SCLK), 64'd0);
        check("abort:mosi", 64'(SPI_MOSI), 64'd0);
        check("abort:busy", 64'(busy), 64'd0);
        check("abort:done", 64'(done), 64'd0);
        check("abort:rd_valid", 64'(rd_valid), 64'd0);
        check("abort:rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("abort:no_done", 64'(done_seen), 64'd0);
        mon_en = 1'b1;
        launch(1'b0, 8'h02, 4'd1, 1'b0);
        collect("after_abort", 1'b0, 8'h02, 64'h0, 1, 5000, 64'hF2);

        // start held high across a whole transaction
        launch(1'b0, 8'h01, 4'd1, 1'b1);
        collect("held1", 1'b0, 8'h01, 64'h0, 1, 5000, 64'h1D);
        check("held:idle_after_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("held:restart_busy", 64'(busy), 64'd1);
        check("held:restart_cs", 64'(SPI_CS), 64'd0);
        start = 1'b0;
        collect("held2", 1'b0, 8'h01, 64'h0, 1, 5000, 64'h1D);

        // Randomized transactions against the reference model
        for (int r = 0; r < 3; r++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = 8'($urandom);
            r_bc   = 4'($urandom_range(0, 2));
            r_wb   = {$urandom, $urandom};
            r_n    = burst_n(int'(r_bc));
            r_rd   = '0;
            for (int k = 0; k < r_n; k++) begin
                a = r_addr + 8'(k);
                r_rd[8 * k +: 8] = ref_regs[a];
            end
            launch(r_wr, r_addr, r_bc, 1'b0);
            collect($sformatf("rand%0d", r), r_wr, r_addr, r_wb, r_n, 2 * H + 16 * H * (2 + r_n), r_rd);
            if (r_wr) ref_write(r_addr, r_n, r_wb);
        end

        check("idle_lines_quiet", 64'(idle_bad), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
